// File: rtl/lenet_dram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lenet_dram_pkg
//  Description : Shared definitions for the lenet DRAM port responder:
//                default address/data widths, the read-request record and
//                a helper for sizing occupancy counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package lenet_dram_pkg;

    localparam int c_ADDR_W = 18;
    localparam int c_DATA_W = 32;

    // One queued read request.
    typedef struct packed {
        logic [c_ADDR_W-1:0] addr;
    } rd_req_t;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/req_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : req_fifo
//  Description : Synchronous FIFO with registered occupancy count.
//                Ports: clk, srst (sync active-high), push/push_data,
//                pop/pop_data (head is visible combinationally), count,
//                full, empty. Pushes when full and pops when empty are
//                ignored. DEPTH must be a power of two so the pointers wrap
//                naturally.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_fifo
    import lenet_dram_pkg::*;
#(
    parameter int WIDTH = c_ADDR_W,
    parameter int DEPTH = 4,
    localparam int c_CNT_W = cnt_width(DEPTH)
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   pop_data,
    output logic [c_CNT_W-1:0] count,
    output logic               full,
    output logic               empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign count     = r_count;
    assign pop_data  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (srst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + c_PTR_W'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count says so.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/dram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dram_responder
//  Description : Memory-side responder for the lenet DRAM port. Accepts read
//                requests (dram_en_rd/addr_in) into a read-address FIFO and
//                write requests (dram_en_wr/addr_out/data_out) into a
//                one-entry write register, serialises them onto a
//                single-port 1-cycle-latency memory (mem_*), and returns
//                read data in order through a READ_LAT+1 stage delay line
//                (dram_valid/data_in). rdy_data gates both request types.
//  Ports       : clk, srst | dram_en_rd, addr_in, dram_en_wr, addr_out,
//                data_out, rdy_data | dram_valid, data_in |
//                mem_en, mem_we, mem_addr, mem_wdata, mem_rdata
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_responder
    import lenet_dram_pkg::*;
#(
    parameter int ADDR_W      = c_ADDR_W,
    parameter int DATA_W      = c_DATA_W,
    parameter int RFIFO_DEPTH = 4,
    parameter int READ_LAT    = 0
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              dram_en_rd,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              dram_en_wr,
    input  logic [ADDR_W-1:0] addr_out,
    input  logic [DATA_W-1:0] data_out,
    output logic              rdy_data,
    output logic              dram_valid,
    output logic [DATA_W-1:0] data_in,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int c_CNT_W  = cnt_width(RFIFO_DEPTH);
    localparam int c_STAGES = READ_LAT + 1;

    // ------------------------------------------------------------------
    // Request acceptance
    // ------------------------------------------------------------------
    logic               r_rdy;
    logic               w_rd_push;
    logic               w_wr_acc;
    logic [ADDR_W-1:0]  w_head;
    logic [c_CNT_W-1:0] w_count;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_full;
    logic               w_empty;

    // r_rdy is preset to 1 by reset and masked while srst is high, so the
    // port reads 0 during reset and 1 in the very first cycle after it.
    assign rdy_data  = r_rdy & ~srst;
    assign w_rd_push = dram_en_rd & rdy_data & ~w_full;
    assign w_wr_acc  = dram_en_wr & rdy_data;

    // ------------------------------------------------------------------
    // Write register
    // ------------------------------------------------------------------
    logic              r_wr_vld;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    // A held write is always issued in the cycle it is visible, so the
    // register simply reloads from this cycle's acceptance.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_vld <= w_wr_acc;
            if (w_wr_acc) begin
                r_wr_addr <= addr_out;
                r_wr_data <= data_out;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue arbiter: held write first, then the read FIFO head
    // ------------------------------------------------------------------
    logic w_issue_wr;
    logic w_issue_rd;

    assign w_issue_wr = r_wr_vld & ~srst;
    assign w_issue_rd = ~r_wr_vld & ~w_empty & ~srst;

    assign mem_en    = w_issue_wr | w_issue_rd;
    assign mem_we    = w_issue_wr;
    assign mem_addr  = w_issue_wr ? r_wr_addr : (w_issue_rd ? w_head : '0);
    assign mem_wdata = w_issue_wr ? r_wr_data : '0;

    req_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (RFIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .srst      (srst),
        .push      (w_rd_push),
        .push_data (addr_in),
        .pop       (w_issue_rd),
        .pop_data  (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // ------------------------------------------------------------------
    // Backpressure: ready next cycle only if the FIFO will have room
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_next = w_count;
        if (w_rd_push && !w_issue_rd) w_cnt_next = w_count + c_CNT_W'(1);
        if (!w_rd_push && w_issue_rd) w_cnt_next = w_count - c_CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (srst) r_rdy <= 1'b1;
        else      r_rdy <= (w_cnt_next < c_CNT_W'(RFIFO_DEPTH));
    end

    // ------------------------------------------------------------------
    // Response path: mem_rdata is valid the cycle after a read issue
    // ------------------------------------------------------------------
    logic              r_rd_issued;
    logic              r_stg_vld [c_STAGES];
    logic [DATA_W-1:0] r_stg_dat [c_STAGES];

    always_ff @(posedge clk) begin
        if (srst) r_rd_issued <= 1'b0;
        else      r_rd_issued <= w_issue_rd;
    end

    // Data only advances alongside a valid bit, so every stage (and hence
    // data_in) keeps the most recent response between strobes.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int k = 0; k < c_STAGES; k++) begin
                r_stg_vld[k] <= 1'b0;
                r_stg_dat[k] <= '0;
            end
        end else begin
            r_stg_vld[0] <= r_rd_issued;
            if (r_rd_issued) r_stg_dat[0] <= mem_rdata;
            for (int k = 1; k < c_STAGES; k++) begin
                r_stg_vld[k] <= r_stg_vld[k-1];
                if (r_stg_vld[k-1]) r_stg_dat[k] <= r_stg_dat[k-1];
            end
        end
    end

    assign dram_valid = r_stg_vld[c_STAGES-1] & ~srst;
    assign data_in    = srst ? '0 : r_stg_dat[c_STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_dram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dram_responder
//  Description : Self-checking bench for dram_responder. A backing memory
//                model answers mem_* accesses; a golden memory plus an
//                in-order expected-response queue is updated from requests
//                as they are accepted (writes applied before same-cycle
//                reads).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_responder;

    localparam int c_AW    = 18;
    localparam int c_DW    = 32;
    localparam int c_DEPTH = 4;
    localparam int c_LAT   = 2;
    localparam int c_MW    = 1024;

    logic            clk = 1'b0;
    logic            srst;
    logic            dram_en_rd;
    logic [c_AW-1:0] addr_in;
    logic            dram_en_wr;
    logic [c_AW-1:0] addr_out;
    logic [c_DW-1:0] data_out;
    logic            rdy_data;
    logic            dram_valid;
    logic [c_DW-1:0] data_in;
    logic            mem_en;
    logic            mem_we;
    logic [c_AW-1:0] mem_addr;
    logic [c_DW-1:0] mem_wdata;
    logic [c_DW-1:0] mem_rdata;

    dram_responder #(
        .ADDR_W      (c_AW),
        .DATA_W      (c_DW),
        .RFIFO_DEPTH (c_DEPTH),
        .READ_LAT    (c_LAT)
    ) dut (
        .clk        (clk),
        .srst       (srst),
        .dram_en_rd (dram_en_rd),
        .addr_in    (addr_in),
        .dram_en_wr (dram_en_wr),
        .addr_out   (addr_out),
        .data_out   (data_out),
        .rdy_data   (rdy_data),
        .dram_valid (dram_valid),
        .data_in    (data_in),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [c_DW-1:0] bmem [c_MW];
    logic [c_DW-1:0] gold [c_MW];
    logic [c_DW-1:0] exp_q [$];
    logic [c_DW-1:0] got_q [$];
    int              got_cyc [$];
    int              acc_rd = 0;
    int              acc_wr = 0;
    int              rdy_low = 0;
    int              first_low_acc = -1;

    // Backing memory: single port, read data valid one cycle after mem_en.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we) bmem[mem_addr[9:0]] = mem_wdata;
            else        mem_rdata <= bmem[mem_addr[9:0]];
        end
    end

    // Reference model and response collector, sampled mid-cycle.
    always @(negedge clk) begin
        if (dram_valid) begin
            got_q.push_back(data_in);
            got_cyc.push_back(cyc);
        end
        if (!srst) begin
            if (!rdy_data) begin
                if (first_low_acc < 0) first_low_acc = acc_rd;
                rdy_low++;
            end
            if (dram_en_wr && rdy_data) begin
                gold[addr_out[9:0]] = data_out;
                acc_wr++;
            end
            if (dram_en_rd && rdy_data) begin
                exp_q.push_back(gold[addr_in[9:0]]);
                acc_rd++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dram_en_rd = 1'b0;
        dram_en_wr = 1'b0;
        addr_in    = '0;
        addr_out   = '0;
        data_out   = '0;
    endtask

    task automatic clear_log();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        acc_rd = 0;
        acc_wr = 0;
        rdy_low = 0;
        first_low_acc = -1;
    endtask

    task automatic wait_responses(input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        repeat (6) tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        srst = 1'b1;
        idle_inputs();
        repeat (3) tick();
        @(negedge clk);
        total++;
        if ({rdy_data, dram_valid, mem_en, mem_we} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: got rdy/vld/en/we=%b want 0000", {rdy_data, dram_valid, mem_en, mem_we});
        end
        total++;
        if (data_in !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            bad++;
            $display("FAIL reset_data: got data_in=%h addr=%h wdata=%h want 0", data_in, mem_addr, mem_wdata);
        end
        tick();
        srst = 1'b0;
        @(negedge clk);
        total++;
        if (rdy_data !== 1'b1) begin
            bad++;
            $display("FAIL reset_rdy: got %b want 1", rdy_data);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_read();
        int c0;
        bmem[10'h010] = 32'hDEADBEEF;
        gold[10'h010] = 32'hDEADBEEF;
        clear_log();
        tick();
        dram_en_rd = 1'b1;
        addr_in    = 18'h00010;
        c0 = cyc;
        tick();
        idle_inputs();
        repeat (3 + c_LAT + 6) tick();
        total++;
        if (got_q.size() != 1) begin
            bad++;
            $display("FAIL single_count: got %0d responses want 1", got_q.size());
        end else begin
            total++;
            if (got_cyc[0] != c0 + 3 + c_LAT) begin
                bad++;
                $display("FAIL single_latency: got cycle %0d want %0d", got_cyc[0], c0 + 3 + c_LAT);
            end
            total++;
            if (got_q[0] !== 32'hDEADBEEF) begin
                bad++;
                $display("FAIL single_data: got %h want deadbeef", got_q[0]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        int c0 = 0;
        int low;
        clear_log();
        for (int i = 0; i < 8; i++) begin
            tick();
            dram_en_rd = 1'b1;
            addr_in    = 18'(i);
            if (i == 0) c0 = cyc;
        end
        tick();
        idle_inputs();
        low = rdy_low;
        wait_responses(8, 40);
        total++;
        if (low != 0) begin
            bad++;
            $display("FAIL b2b_rdy: rdy_data low for %0d cycles want 0", low);
        end
        total++;
        if (got_q.size() != 8) begin
            bad++;
            $display("FAIL b2b_count: got %0d responses want 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (got_q[i] !== gold[i] || got_cyc[i] != c0 + 3 + c_LAT + i) begin
                    bad++;
                    $display("FAIL b2b_resp%0d: got %h@%0d want %h@%0d", i, got_q[i], got_cyc[i], gold[i], c0 + 3 + c_LAT + i);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_same_cycle();
        int c0;
        clear_log();
        tick();
        dram_en_wr = 1'b1;
        addr_out   = 18'h0003F;
        data_out   = 32'h12345678;
        dram_en_rd = 1'b1;
        addr_in    = 18'h0003F;
        c0 = cyc;
        tick();
        idle_inputs();
        @(negedge clk);
        total++;
        if (!(mem_en === 1'b1 && mem_we === 1'b1 && mem_addr === 18'h0003F && mem_wdata === 32'h12345678)) begin
            bad++;
            $display("FAIL samecyc_wr_issue: got en=%b we=%b addr=%h wd=%h want 1 1 0003f 12345678", mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        total++;
        if (!(mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === 18'h0003F)) begin
            bad++;
            $display("FAIL samecyc_rd_issue: got en=%b we=%b addr=%h want 1 0 0003f", mem_en, mem_we, mem_addr);
        end
        repeat (4 + c_LAT + 4) tick();
        total++;
        if (got_q.size() != 1 || got_q[0] !== 32'h12345678 || got_cyc[0] != c0 + 4 + c_LAT) begin
            bad++;
            $display("FAIL samecyc_resp: got n=%0d data=%h@%0d want 1 12345678@%0d", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 32'h0, (got_cyc.size() > 0) ? got_cyc[0] : -1, c0 + 4 + c_LAT);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_fill();
        logic [c_DW-1:0] wdat [8];
        int guard = 0;
        int diffs = 0;
        for (int k = 0; k < 8; k++) wdat[k] = $urandom;
        clear_log();
        while ((acc_rd < 4 || acc_wr < 8) && guard < 100) begin
            tick();
            dram_en_rd = (acc_rd < 4);
            addr_in    = 18'(12'h040 + acc_rd);
            dram_en_wr = (acc_wr < 8);
            addr_out   = 18'(12'h300 + acc_wr);
            data_out   = wdat[(acc_wr < 8) ? acc_wr : 0];
            guard++;
        end
        tick();
        idle_inputs();
        wait_responses(4, 40);
        total++;
        if (acc_rd != 4 || acc_wr != 8) begin
            bad++;
            $display("FAIL fill_accepts: got rd=%0d wr=%0d want 4 8", acc_rd, acc_wr);
        end
        total++;
        if (rdy_low == 0 || first_low_acc != 4) begin
            bad++;
            $display("FAIL fill_backpressure: low cycles=%0d reads at first low=%0d want >0 and 4", rdy_low, first_low_acc);
        end
        total++;
        if (got_q.size() != 4) begin
            bad++;
            $display("FAIL fill_count: got %0d responses want 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got_q[i] !== gold[12'h040 + i]) begin
                    bad++;
                    $display("FAIL fill_resp%0d: got %h want %h", i, got_q[i], gold[12'h040 + i]);
                end
            end
        end
        for (int k = 0; k < 8; k++) if (bmem[12'h300 + k] !== wdat[k]) diffs++;
        total++;
        if (diffs != 0) begin
            bad++;
            $display("FAIL fill_writes: got %0d wrong words want 0", diffs);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        int prd;
        int pwr;
        int diffs = 0;
        int nerr = 0;
        clear_log();
        prd = acc_rd;
        pwr = acc_wr;
        for (int n = 0; n < 300; n++) begin
            tick();
            if (!(dram_en_rd && acc_rd == prd)) begin
                dram_en_rd = ($urandom_range(0, 99) < 60);
                addr_in    = 18'($urandom_range(0, 511));
            end
            if (!(dram_en_wr && acc_wr == pwr)) begin
                dram_en_wr = ($urandom_range(0, 99) < 40);
                addr_out   = 18'($urandom_range(512, 1023));
                data_out   = $urandom;
            end
            prd = acc_rd;
            pwr = acc_wr;
        end
        tick();
        idle_inputs();
        wait_responses(exp_q.size(), 200);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_count: got %0d responses want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) nerr++;
            total++;
            if (nerr != 0) begin
                bad++;
                $display("FAIL rand_data: got %0d wrong responses of %0d want 0", nerr, exp_q.size());
            end
        end
        for (int a = 0; a < c_MW; a++) if (bmem[a] !== gold[a]) diffs++;
        total++;
        if (diffs != 0) begin
            bad++;
            $display("FAIL rand_mem_image: got %0d differing words want 0", diffs);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        int c1;
        clear_log();
        for (int i = 0; i < 3; i++) begin
            tick();
            dram_en_rd = 1'b1;
            addr_in    = 18'(12'h050 + i);
        end
        tick();
        idle_inputs();
        srst = 1'b1;
        @(negedge clk);
        total++;
        if ({rdy_data, dram_valid, mem_en, mem_we} !== 4'b0000 ||
            data_in !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
            bad++;
            $display("FAIL midrst_outputs: got rdy/vld/en/we=%b data=%h addr=%h wd=%h want all 0",
                     {rdy_data, dram_valid, mem_en, mem_we}, data_in, mem_addr, mem_wdata);
        end
        tick();
        srst = 1'b0;
        @(negedge clk);
        total++;
        if (rdy_data !== 1'b1) begin
            bad++;
            $display("FAIL midrst_rdy: got %b want 1", rdy_data);
        end
        repeat (10) tick();
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL midrst_dropped: got %0d responses want 0", got_q.size());
        end
        clear_log();
        tick();
        dram_en_rd = 1'b1;
        addr_in    = 18'h00060;
        c1 = cyc;
        tick();
        idle_inputs();
        repeat (3 + c_LAT + 5) tick();
        total++;
        if (got_q.size() != 1 || got_q[0] !== gold[12'h060] || got_cyc[0] != c1 + 3 + c_LAT) begin
            bad++;
            $display("FAIL midrst_newread: got n=%0d data=%h@%0d want 1 %h@%0d", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 32'h0, (got_cyc.size() > 0) ? got_cyc[0] : -1,
                     gold[12'h060], c1 + 3 + c_LAT);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        srst = 1'b1;
        dram_en_rd = 1'b0;
        dram_en_wr = 1'b0;
        addr_in    = '0;
        addr_out   = '0;
        data_out   = '0;
        for (int a = 0; a < c_MW; a++) begin
            bmem[a] = $urandom;
            gold[a] = bmem[a];
        end
        test_reset();
        test_single_read();
        test_back_to_back();
        test_same_cycle();
        test_fill();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dram_responder.md
# dram_responder

Memory-side responder for the lenet DRAM port: accepts the accelerator's read requests (`dram_en_rd`/`addr_in`) and write requests (`dram_en_wr`/`addr_out`/`data_out`), serialises them onto a single-port, 1-cycle-latency backing memory, and returns read data in order with a `dram_valid` strobe. It sits between `CHIP` and the SRAM/DRAM model in the testbench, and between `CHIP` and the memory macro in the FPGA build.

## Interface
- `ADDR_W`, 18: word address width.
- `DATA_W`, 32: data width.
- `RFIFO_DEPTH`, 4: read-address queue depth (power of 2, ≥2).
- `READ_LAT`, 0: extra read-response delay stages (0..7).

- `clk` in 1: single clock; all logic on rising edge.
- `srst` in 1: synchronous, active-high reset.
- `dram_en_rd` in 1: read request; accepted when `rdy_data`=1.
- `addr_in` in ADDR_W: read address, sampled with `dram_en_rd`.
- `dram_en_wr` in 1: write request; accepted when `rdy_data`=1.
- `addr_out` in ADDR_W: write address.
- `data_out` in DATA_W: write data.
- `rdy_data` out 1: responder can accept requests this cycle.
- `dram_valid` out 1: one-cycle strobe; `data_in` holds read data.
- `data_in` out DATA_W: read response data.
- `mem_en` out 1: backing-memory access strobe.
- `mem_we` out 1: 1 = write, 0 = read (valid with `mem_en`).
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: memory address/data.
- `mem_rdata` in DATA_W: memory read data, valid the cycle after a read `mem_en`.

## Operation
- Accept: a read is accepted when `dram_en_rd & rdy_data`; its address is pushed into the read FIFO at the edge. A write is accepted when `dram_en_wr & rdy_data`; address and data are captured into a one-entry write register at the edge.
- Issue arbiter, each cycle: a held write has priority → `mem_en`=1, `mem_we`=1, write register cleared. Otherwise, if the FIFO is non-empty → `mem_en`=1, `mem_we`=0, `mem_addr`=FIFO head, pop. Otherwise `mem_en`=0.
- The write register always drains the cycle after capture, so writes never need backpressure.
- Ordering: a write and a read accepted in the same cycle go write first, so a read to the same address returns the new data. Reads complete strictly in acceptance order.
- Response: a read issued in cycle n captures `mem_rdata` in cycle n+1 into a delay line of READ_LAT+1 registered stages (valid bit plus data). The stage output drives `dram_valid`/`data_in`. When `dram_valid`=0, `data_in` holds its last value.
- Backpressure: `rdy_data` is registered as (next FIFO count < RFIFO_DEPTH). A push and a pop in the same cycle leave the count unchanged.
- Requests presented while `rdy_data`=0 are ignored. The requester must hold them.
- Reset: while `srst`=1, the FIFO empties, the write register clears and the delay line flushes. Outputs `rdy_data`, `dram_valid`, `mem_en` and `mem_we` are 0. `data_in`, `mem_addr` and `mem_wdata` are 0. Requests in flight are dropped and no response is produced for them. `rdy_data` rises the first cycle after `srst` falls.

## Timing
- Unobstructed read: request in cycle 0 → `mem_en` in cycle 1 → `mem_rdata` in cycle 2 → `dram_valid` in cycle 3+READ_LAT.
- Each write held ahead of a read delays that read's issue, and its response, by one cycle.
- Throughput: one memory access per cycle. Sustained reads return one response per cycle.
- Count range 0..RFIFO_DEPTH. Pointers wrap modulo RFIFO_DEPTH.

## Structure
- `lenet_dram_pkg`: ADDR_W/DATA_W defaults and the request struct {addr}.
- Sub-module `req_fifo`: synchronous FIFO with push/pop/count/full/empty, parameterised by width and depth.
- Top level contains the write register, the arbiter and the delay line.

## Test plan
- Single read: preload mem[0x00010]=0xDEADBEEF, READ_LAT=0. Read at cycle 0 → `dram_valid`=1 and `data_in`=0xDEADBEEF in cycle 3 only.
- Back-to-back reads of 0x0..0x7 with READ_LAT=2: eight consecutive `dram_valid` cycles starting in cycle 5, data in address order. `rdy_data` never drops.
- Same-cycle write 0x0003F←0x12345678 and read 0x0003F: write issued in cycle 1, read in cycle 2. `dram_valid` in cycle 4 with 0x12345678.
- Fill: writes every cycle plus reads every cycle, RFIFO_DEPTH=4. `rdy_data` falls after the FIFO reaches 4 entries. Requests held while `rdy_data`=0 are not duplicated. All 4 responses are correct and in order.
- Reset mid-stream: assert `srst` one cycle with 3 reads outstanding. No `dram_valid` follows, all outputs are 0 during reset, `rdy_data`=1 the next cycle, and a new read then completes in 3 cycles.
